// File: rtl/bm_pkg.sv
// Shared types and constants for the census best-match block: coordinate layout,
// cost width derivation and the job FSM encoding.
package bm_pkg;

    localparam int COORD_W = 16;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
    } coord_t;

    // Bits needed to hold a popcount of 0..bits inclusive.
    function automatic int cost_width(input int bits);
        return $clog2(bits + 1);
    endfunction

    localparam int COST_W = cost_width(16 * 16);
    localparam logic [COST_W-1:0] COST_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/popcount_chunk.sv
// Population count of one chunk of the XORed census block.
module popcount_chunk #(
    parameter int chunk_w = 16,
    parameter int count_w = $clog2(chunk_w) + 1
) (
    input  logic [chunk_w-1:0] bits,
    output logic [count_w-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < chunk_w; i++) begin
            count = count + count_w'(bits[i]);
        end
    end

endmodule

// File: rtl/census_best_match.sv
// Hamming-cost block matcher: 3-stage XOR/popcount pipeline feeding a best and
// second-best tracker, one result per search job over a valid/ready handshake.
//
// state    | meaning
// ST_IDLE  | no job open; leaves as soon as a candidate is in flight
// ST_ACCUM | job open, candidates being absorbed by the compare stage
// ST_DRAIN | job closed by srch_done rise; waiting for its candidates to clear S1/S2
// ST_EMIT  | one cycle: accumulator copied to outputs and restarted
module census_best_match
    import bm_pkg::*;
#(
    parameter int block_width  = 16,
    parameter int block_height = 16,
    parameter int chunk_w      = 16,
    parameter int cost_w       = cost_width(block_width * block_height)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                blks_valid,
    input  logic [block_width*block_height-1:0] blk_block,
    input  logic [block_width*block_height-1:0] srch_block,
    input  logic [15:0]                         coords_in,
    input  logic [15:0]                         blk_index_in,
    input  logic                                srch_done,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic [15:0]                         best_coords,
    output logic [cost_w-1:0]                   best_cost,
    output logic [cost_w-1:0]                   second_cost,
    output logic [15:0]                         result_index,
    output logic                                busy,
    output logic                                overflow
);

    localparam int n_bits   = block_width * block_height;
    localparam int n_chunks = n_bits / chunk_w;
    localparam int pc_w     = $clog2(chunk_w) + 1;
    localparam logic [cost_w-1:0] cost_max = '1;

    state_t state, state_next;

    logic srch_done_d;
    logic srch_done_rise;
    logic job_tag;
    logic end_job;
    logic any_pending;
    logic old_pending;
    logic emit;

    logic              s1_valid, s1_tag;
    logic [n_bits-1:0] s1_xor;
    coord_t            s1_coords;
    logic [15:0]       s1_index;

    logic              s2_valid, s2_tag;
    logic [pc_w-1:0]   pc_next [n_chunks];
    logic [pc_w-1:0]   s2_pc   [n_chunks];
    coord_t            s2_coords;
    logic [15:0]       s2_index;

    logic              s3_valid;
    logic [cost_w-1:0] pc_sum;
    logic [cost_w-1:0] s3_cost;
    coord_t            s3_coords;
    logic [15:0]       s3_index;

    logic              acc_have;
    logic [cost_w-1:0] acc_best, acc_second;
    coord_t            acc_coords;
    logic [15:0]       acc_index;

    assign srch_done_rise = srch_done & ~srch_done_d;
    assign any_pending    = s1_valid | s2_valid | s3_valid;
    // After the tag flips, entries still carrying the previous tag belong to the closing job.
    // S3 needs no tag: it is absorbed in the same cycle DRAIN sees S1/S2 clear.
    assign old_pending    = (s1_valid && (s1_tag != job_tag)) ||
                            (s2_valid && (s2_tag != job_tag));
    assign emit           = (state == ST_EMIT);
    assign busy           = (state != ST_IDLE);

    for (genvar g = 0; g < n_chunks; g++) begin : g_chunk
        popcount_chunk #(
            .chunk_w (chunk_w),
            .count_w (pc_w)
        ) u_popcount (
            .bits  (s1_xor[g*chunk_w +: chunk_w]),
            .count (pc_next[g])
        );
    end

    always_comb begin
        pc_sum = '0;
        for (int i = 0; i < n_chunks; i++) begin
            pc_sum = pc_sum + cost_w'(s2_pc[i]);
        end
    end

    always_comb begin
        state_next = state;
        end_job    = 1'b0;
        case (state)
            ST_IDLE: begin
                // A one-candidate job can close before IDLE has seen S1 valid.
                if (srch_done_rise && (blks_valid || any_pending)) begin
                    end_job    = 1'b1;
                    state_next = ST_DRAIN;
                end else if (any_pending) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (srch_done_rise) begin
                    end_job    = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!old_pending) begin
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            srch_done_d <= 1'b1;
            job_tag     <= 1'b0;
            s1_valid    <= 1'b0;
            s1_tag      <= 1'b0;
            s2_valid    <= 1'b0;
            s2_tag      <= 1'b0;
            s3_valid    <= 1'b0;
        end else begin
            state       <= state_next;
            srch_done_d <= srch_done;
            if (end_job) begin
                job_tag <= ~job_tag;
            end
            s1_valid <= blks_valid;
            s1_tag   <= job_tag;
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s3_valid <= s2_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (blks_valid) begin
            s1_xor    <= blk_block ^ srch_block;
            s1_coords <= coords_in;
            s1_index  <= blk_index_in;
        end
        if (s1_valid) begin
            for (int i = 0; i < n_chunks; i++) begin
                s2_pc[i] <= pc_next[i];
            end
            s2_coords <= s1_coords;
            s2_index  <= s1_index;
        end
        if (s2_valid) begin
            s3_cost   <= pc_sum;
            s3_coords <= s2_coords;
            s3_index  <= s2_index;
        end
    end

    // In EMIT an arriving S3 entry is the first candidate of the next job.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_have   <= 1'b0;
            acc_best   <= '0;
            acc_second <= cost_max;
            acc_coords <= '0;
            acc_index  <= '0;
        end else if (s3_valid && (emit || !acc_have)) begin
            acc_have   <= 1'b1;
            acc_best   <= s3_cost;
            acc_second <= cost_max;
            acc_coords <= s3_coords;
            acc_index  <= s3_index;
        end else if (emit) begin
            acc_have   <= 1'b0;
            acc_best   <= '0;
            acc_second <= cost_max;
            acc_coords <= '0;
            acc_index  <= '0;
        end else if (s3_valid) begin
            if (s3_cost < acc_best) begin
                acc_second <= acc_best;
                acc_best   <= s3_cost;
                acc_coords <= s3_coords;
            end else if (s3_cost < acc_second) begin
                acc_second <= s3_cost;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            best_coords  <= '0;
            best_cost    <= '0;
            second_cost  <= cost_max;
            result_index <= '0;
        end else if (emit) begin
            result_valid <= 1'b1;
            best_coords  <= acc_coords;
            best_cost    <= acc_best;
            second_cost  <= acc_second;
            result_index <= acc_index;
            if (result_valid && !result_ready) begin
                overflow <= 1'b1;
            end
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_census_best_match.sv
// Directed bench for census_best_match: expected results are queued when a job
// is closed and checked against the DUT when the result handshake occurs.
module tb_census_best_match;
    import bm_pkg::*;

    localparam int BW = 16;
    localparam int BH = 16;
    localparam int NB = BW * BH;
    localparam int CW = 9;

    typedef struct {
        logic [15:0]   coords;
        logic [CW-1:0] best;
        logic [CW-1:0] second;
        logic [15:0]   idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          blks_valid;
    logic [NB-1:0] blk_block;
    logic [NB-1:0] srch_block;
    logic [15:0]   coords_in;
    logic [15:0]   blk_index_in;
    logic          srch_done;
    logic          result_valid;
    logic          result_ready;
    logic [15:0]   best_coords;
    logic [CW-1:0] best_cost;
    logic [CW-1:0] second_cost;
    logic [15:0]   result_index;
    logic          busy;
    logic          overflow;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   t2_costs [5] = '{50, 30, 30, 10, 80};

    bit            m_have;
    logic [CW-1:0] m_best, m_second;
    logic [15:0]   m_coords, m_idx;

    always #5 clk = ~clk;

    census_best_match #(
        .block_width  (BW),
        .block_height (BH),
        .chunk_w      (16),
        .cost_w       (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .blks_valid   (blks_valid),
        .blk_block    (blk_block),
        .srch_block   (srch_block),
        .coords_in    (coords_in),
        .blk_index_in (blk_index_in),
        .srch_done    (srch_done),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .best_coords  (best_coords),
        .best_cost    (best_cost),
        .second_cost  (second_cost),
        .result_index (result_index),
        .busy         (busy),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB-1:0] rand_block();
        logic [NB-1:0] v;
        for (int i = 0; i < NB / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [NB-1:0] mask_n(input int n);
        logic [NB-1:0] m;
        m = '0;
        while ($countones(m) < n) m[$urandom_range(0, NB-1)] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_have   = 1'b0;
        m_best   = '0;
        m_second = COST_MAX;
        m_coords = '0;
        m_idx    = '0;
    endtask

    task automatic model_add(input logic [CW-1:0] c, input logic [15:0] xy, input logic [15:0] idx);
        if (!m_have) begin
            m_have = 1'b1; m_best = c; m_second = COST_MAX; m_coords = xy; m_idx = idx;
        end else if (c < m_best) begin
            m_second = m_best; m_best = c; m_coords = xy;
        end else if (c < m_second) begin
            m_second = c;
        end
    endtask

    task automatic send(input logic [NB-1:0] b, input logic [NB-1:0] s,
                        input logic [15:0] xy, input logic [15:0] idx);
        blks_valid   = 1'b1;
        blk_block    = b;
        srch_block   = s;
        coords_in    = xy;
        blk_index_in = idx;
        model_add(CW'($countones(b ^ s)), xy, idx);
        tick();
        blks_valid = 1'b0;
    endtask

    task automatic send_cost(input int cost, input logic [15:0] xy, input logic [15:0] idx);
        logic [NB-1:0] b;
        b = rand_block();
        send(b, b ^ mask_n(cost), xy, idx);
    endtask

    task automatic close_job(input bit keep);
        exp_t e;
        if (m_have && keep) begin
            e.coords = m_coords; e.best = m_best; e.second = m_second; e.idx = m_idx;
            sb.push_back(e);
        end
        model_reset();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, sb.size(), 0);
        tick();
    endtask

    initial begin
        int n;
        bit seen_v, seen_b;
        reset        = 1'b1;
        blks_valid   = 1'b0;
        blk_block    = '0;
        srch_block   = '0;
        coords_in    = '0;
        blk_index_in = '0;
        srch_done    = 1'b1;
        result_ready = 1'b1;
        model_reset();

        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (result_valid === 1'b1 && result_ready === 1'b1) begin
                        chk("result_expected", (sb.size() > 0), 1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            chk("best_cost", best_cost, e.best);
                            chk("second_cost", second_cost, e.second);
                            chk("best_coords", best_coords, e.coords);
                            chk("result_index", result_index, e.idx);
                        end
                    end
                end
            end
        join_none

        // reset state
        repeat (3) tick();
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_best_cost", best_cost, 0);
        chk("rst_second_cost", second_cost, 9'h1FF);
        chk("rst_best_coords", best_coords, 0);
        chk("rst_result_index", result_index, 0);
        reset = 1'b0;
        tick();

        // single candidate, cost 4
        srch_done = 1'b0;
        tick();
        send('0, 256'hF, 16'h0000, 16'h0001);
        srch_done = 1'b1;
        close_job(1);
        n = 0;
        while (result_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("t1_result_latency", (result_valid === 1'b1 && n <= 5), 1);
        chk("t1_best_cost", best_cost, 4);
        chk("t1_second_cost", second_cost, 9'h1FF);
        tick();
        chk("t1_valid_drop", result_valid, 0);
        chk("t1_busy_idle", busy, 0);

        // 48 candidates, best 10 at 0x0003, ties at 30
        srch_done = 1'b0;
        tick();
        for (int i = 0; i < 48; i++) begin
            send_cost((i < 5) ? t2_costs[i] : int'($urandom_range(31, 120)), 16'(i), 16'h0002);
        end
        srch_done = 1'b1;
        close_job(1);
        wait_drain("t2_drain", 20);

        // tie on the best cost keeps the earlier coords
        srch_done = 1'b0;
        tick();
        send_cost(40, 16'h0010, 16'h0003);
        send_cost(5,  16'h0011, 16'h0003);
        send_cost(5,  16'h0012, 16'h0003);
        send_cost(9,  16'h0013, 16'h0003);
        srch_done = 1'b1;
        close_job(1);
        wait_drain("tie_drain", 20);

        // done rises together with the final candidate
        srch_done = 1'b0;
        tick();
        send_cost(20, 16'h0100, 16'h0004);
        send_cost(15, 16'h0101, 16'h0004);
        srch_done = 1'b1;
        send_cost(0, 16'h0102, 16'h0004);
        close_job(1);
        wait_drain("t3_drain", 20);

        // next job's candidates arrive while the previous job drains
        srch_done = 1'b0;
        tick();
        send_cost(40, 16'h0200, 16'h0005);
        srch_done = 1'b1;
        send_cost(25, 16'h0201, 16'h0005);
        close_job(1);
        srch_done = 1'b0;
        send_cost(60, 16'h0300, 16'h0006);
        send_cost(33, 16'h0301, 16'h0006);
        send_cost(5,  16'h0302, 16'h0006);
        send_cost(5,  16'h0303, 16'h0006);
        send_cost(70, 16'h0304, 16'h0006);
        srch_done = 1'b1;
        close_job(1);
        wait_drain("overlap_drain", 30);
        chk("no_overflow_with_ready", overflow, 0);

        // ready held low across two jobs
        result_ready = 1'b0;
        srch_done = 1'b0;
        tick();
        send_cost(7, 16'h0010, 16'h0007);
        send_cost(9, 16'h0011, 16'h0007);
        srch_done = 1'b1;
        close_job(0);
        n = 0;
        while (result_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("t4_first_valid", result_valid, 1);
        chk("t4_first_best", best_cost, 7);
        srch_done = 1'b0;
        tick();
        send_cost(12, 16'h0020, 16'h0008);
        send_cost(20, 16'h0021, 16'h0008);
        srch_done = 1'b1;
        close_job(1);
        repeat (2) tick();
        n = 0;
        while (busy === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("t4_busy_done", busy, 0);
        chk("t4_overflow", overflow, 1);
        chk("t4_still_valid", result_valid, 1);
        chk("t4_overwritten_best", best_cost, 12);
        chk("t4_overwritten_coords", best_coords, 16'h0020);
        result_ready = 1'b1;
        tick();
        chk("t4_valid_drop", result_valid, 0);
        chk("t4_overflow_sticky", overflow, 1);
        chk("t4_scoreboard", sb.size(), 0);

        // reset mid-job discards everything
        srch_done = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) send_cost(3 + i, 16'(16'h0400 + i), 16'h0009);
        model_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        srch_done = 1'b1;
        seen_v = 1'b0;
        seen_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_v |= (result_valid === 1'b1);
            seen_b |= (busy === 1'b1);
        end
        chk("t5_no_result", seen_v, 0);
        chk("t5_busy", seen_b, 0);
        chk("t5_second_cost", second_cost, 9'h1FF);
        chk("t5_overflow_cleared", overflow, 0);

        // done rise with no candidates
        srch_done = 1'b0;
        repeat (2) tick();
        srch_done = 1'b1;
        seen_v = 1'b0;
        seen_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_v |= (result_valid === 1'b1);
            seen_b |= (busy === 1'b1);
        end
        chk("t6_no_result", seen_v, 0);
        chk("t6_busy", seen_b, 0);

        // random job over full-width blocks
        srch_done = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            send_cost($urandom_range(0, 200), 16'($urandom()), 16'h00AA);
        end
        srch_done = 1'b1;
        close_job(1);
        wait_drain("rand_drain", 20);

        repeat (5) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
